kmap_eval: RTL and testbench

KMAP_EVAL -- requirements
Module: kmap_eval

---
 rtl/kmap_pkg.sv | 13 +
 rtl/kmap_scan.sv | 95 +++++++++
 rtl/kmap_eval.sv | 67 ++++++
 tb/tb_kmap_eval.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kmap_pkg.sv
// rtl/kmap_pkg.sv - shared state encoding and default truth table for kmap_eval
// Contents: state_t (scanner FSM states), KMAP_DEFAULT_TABLE (minterms 0,1,2,4,6,12,14)
package kmap_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] KMAP_DEFAULT_TABLE = 16'h5057;

endpackage

// File: rtl/kmap_scan.sv
// rtl/kmap_scan.sv - minterm-count scanner: FSM, index counter and accumulator
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   scan_start          request a scan (accepted in IDLE only)
//   table_bits          current truth table contents
//   scan_busy           high while in SCAN
//   scan_done           one-cycle pulse in DONE
//   wr_ready            low in SCAN, so the table is stable while being counted
//   minterm_count       number of ones found by the last completed scan
module kmap_scan
  import kmap_pkg::*;
#(
  parameter int NIN = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scan_start,
  input  logic [(1<<NIN)-1:0]   table_bits,
  output logic                  scan_busy,
  output logic                  scan_done,
  output logic                  wr_ready,
  output logic [NIN:0]          minterm_count
);

  localparam logic [NIN-1:0] LAST_IDX = '1;
  localparam logic [NIN-1:0] ONE_IDX  = {{(NIN-1){1'b0}}, 1'b1};

  state_t         state_q, state_d;
  logic [NIN-1:0] idx_q;
  logic [NIN:0]   acc_q;
  logic [NIN:0]   count_q;
  logic [NIN:0]   acc_sum;

  // Accumulator including the bit examined this cycle; on the last index it
  // is the final count, so minterm_count is already valid while in DONE.
  assign acc_sum = acc_q + {{NIN{1'b0}}, table_bits[idx_q]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (scan_start) state_d = SCAN;
      SCAN:    if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= '0;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (scan_start) begin
            idx_q <= '0;
            acc_q <= '0;
          end
        end
        SCAN: begin
          acc_q <= acc_sum;
          idx_q <= idx_q + ONE_IDX;
          if (idx_q == LAST_IDX) count_q <= acc_sum;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    scan_busy = 1'b0;
    scan_done = 1'b0;
    wr_ready  = 1'b1;
    case (state_q)
      SCAN: begin
        scan_busy = 1'b1;
        wr_ready  = 1'b0;
      end
      DONE:    scan_done = 1'b1;
      default: ;
    endcase
  end

  assign minterm_count = count_q;

endmodule

// File: rtl/kmap_eval.sv
// rtl/kmap_eval.sv - programmable truth-table evaluator with minterm-count scan
// Ports:
//   clk, reset                rising-edge clock, synchronous active-high reset
//   x, eval_en, inv           evaluate table[x] (complemented when inv=1)
//   f, f_valid                registered result and its one-cycle qualifier
//   wr_en, wr_addr, wr_data   truth-table write port, gated by wr_ready
//   wr_ready                  writes accepted (low while scanning)
//   scan_start, scan_busy,
//   scan_done, minterm_count  minterm-count scan control and result
module kmap_eval
  import kmap_pkg::*;
#(
  parameter int                   NIN        = 4,
  parameter logic [(1<<NIN)-1:0]  TABLE_INIT = KMAP_DEFAULT_TABLE
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NIN-1:0] x,
  input  logic           eval_en,
  input  logic           inv,
  output logic           f,
  output logic           f_valid,
  input  logic           wr_en,
  input  logic [NIN-1:0] wr_addr,
  input  logic           wr_data,
  output logic           wr_ready,
  input  logic           scan_start,
  output logic           scan_busy,
  output logic           scan_done,
  output logic [NIN:0]   minterm_count
);

  logic [(1<<NIN)-1:0] table_q;
  logic                f_q;
  logic                f_valid_q;

  // Eval reads table_q before the same-edge write lands, giving
  // read-before-write ordering on a shared index.
  always_ff @(posedge clk) begin
    if (reset) begin
      table_q   <= TABLE_INIT;
      f_q       <= 1'b0;
      f_valid_q <= 1'b0;
    end else begin
      f_valid_q <= eval_en;
      if (eval_en) f_q <= table_q[x] ^ inv;
      if (wr_en && wr_ready) table_q[wr_addr] <= wr_data;
    end
  end

  assign f       = f_q;
  assign f_valid = f_valid_q;

  kmap_scan #(
    .NIN(NIN)
  ) u_scan (
    .clk           (clk),
    .reset         (reset),
    .scan_start    (scan_start),
    .table_bits    (table_q),
    .scan_busy     (scan_busy),
    .scan_done     (scan_done),
    .wr_ready      (wr_ready),
    .minterm_count (minterm_count)
  );

endmodule

// File: tb/tb_kmap_eval.sv
// tb/tb_kmap_eval.sv - self-checking bench for kmap_eval
module tb_kmap_eval;

  logic clk = 1'b0;
  logic reset;

  logic [3:0] a_x;
  logic       a_eval_en, a_inv, a_f, a_fv;
  logic       a_wr_en, a_wr_data, a_wr_ready;
  logic [3:0] a_wr_addr;
  logic       a_scan_start, a_busy, a_done;
  logic [4:0] a_count;

  logic [2:0] b_x;
  logic       b_eval_en, b_inv, b_f, b_fv;
  logic       b_wr_en, b_wr_data, b_wr_ready;
  logic [2:0] b_wr_addr;
  logic       b_scan_start, b_busy, b_done;
  logic [3:0] b_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] mt;
  logic        prev_f;

  always #5 clk = ~clk;

  kmap_eval u_a (
    .clk(clk), .reset(reset), .x(a_x), .eval_en(a_eval_en), .inv(a_inv),
    .f(a_f), .f_valid(a_fv), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
    .wr_data(a_wr_data), .wr_ready(a_wr_ready), .scan_start(a_scan_start),
    .scan_busy(a_busy), .scan_done(a_done), .minterm_count(a_count)
  );

  kmap_eval #(.NIN(3), .TABLE_INIT(8'hFF)) u_b (
    .clk(clk), .reset(reset), .x(b_x), .eval_en(b_eval_en), .inv(b_inv),
    .f(b_f), .f_valid(b_fv), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .wr_ready(b_wr_ready), .scan_start(b_scan_start),
    .scan_busy(b_busy), .scan_done(b_done), .minterm_count(b_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference table built from the minterm list rather than the hex constant.
  function automatic logic [15:0] default_model();
    int mins[7] = '{0, 1, 2, 4, 6, 12, 14};
    logic [15:0] t = '0;
    foreach (mins[i]) t[mins[i]] = 1'b1;
    return t;
  endfunction

  function automatic int model_count(input logic [15:0] t);
    int c = 0;
    for (int i = 0; i < 16; i++) c += int'(t[i]);
    return c;
  endfunction

  task automatic eval_check(input logic [3:0] xi, input logic iv, input string tag);
    logic e;
    e = mt[xi] ^ iv;
    a_x = xi;
    a_inv = iv;
    a_eval_en = 1'b1;
    tick;
    chk({tag, " f"}, {31'd0, a_f}, {31'd0, e});
    chk({tag, " valid"}, {31'd0, a_fv}, 32'd1);
    a_eval_en = 1'b0;
    a_inv = ~iv;
    tick;
    chk({tag, " valid-low"}, {31'd0, a_fv}, 32'd0);
    chk({tag, " f-hold"}, {31'd0, a_f}, {31'd0, e});
    prev_f = e;
  endtask

  task automatic run_scan_a(input int exp_cnt, input string tag);
    int busy_n = 0;
    int nready_n = 0;
    int guard = 0;
    a_scan_start = 1'b1;
    tick;
    a_scan_start = 1'b0;
    while (!a_done && guard < 100) begin
      if (a_busy) busy_n++;
      if (!a_wr_ready) nready_n++;
      tick;
      guard++;
    end
    chk({tag, " done-seen"}, {31'd0, a_done}, 32'd1);
    chk({tag, " busy-cycles"}, busy_n, 16);
    chk({tag, " wr_ready-low-cycles"}, nready_n, 16);
    chk({tag, " count"}, {27'd0, a_count}, exp_cnt);
    tick;
    chk({tag, " done-pulse-width"}, {31'd0, a_done}, 32'd0);
    chk({tag, " count-hold"}, {27'd0, a_count}, exp_cnt);
  endtask

  initial begin
    logic nb;
    logic exp_f, exp_v;
    int guard;
    int busy_n;
    logic done_seen;

    reset = 1'b1;
    a_x = '0; a_eval_en = 0; a_inv = 0; a_wr_en = 0; a_wr_addr = '0;
    a_wr_data = 0; a_scan_start = 0;
    b_x = '0; b_eval_en = 0; b_inv = 0; b_wr_en = 0; b_wr_addr = '0;
    b_wr_data = 0; b_scan_start = 0;
    prev_f = 1'b0;
    tick;
    tick;
    chk("reset f", {31'd0, a_f}, 32'd0);
    chk("reset f_valid", {31'd0, a_fv}, 32'd0);
    chk("reset busy", {31'd0, a_busy}, 32'd0);
    chk("reset done", {31'd0, a_done}, 32'd0);
    chk("reset count", {27'd0, a_count}, 32'd0);
    chk("reset wr_ready", {31'd0, a_wr_ready}, 32'd1);
    reset = 1'b0;
    mt = default_model();

    for (int i = 0; i < 16; i++) eval_check(4'(i), 1'b0, $sformatf("sweep0 x=%0d", i));
    for (int i = 0; i < 16; i++) eval_check(4'(i), 1'b1, $sformatf("sweep1 x=%0d", i));

    run_scan_a(7, "scan-default");

    a_wr_en = 1'b1; a_wr_addr = 4'd15; a_wr_data = 1'b1;
    tick;
    a_wr_addr = 4'd0; a_wr_data = 1'b0;
    tick;
    a_wr_en = 1'b0;
    mt[15] = 1'b1;
    mt[0] = 1'b0;
    run_scan_a(7, "scan-after-writes");

    // Random writes and evals while idle, including same-index collisions.
    for (int i = 0; i < 40; i++) begin
      a_wr_en   = 1'($urandom_range(0, 1));
      a_wr_addr = 4'($urandom_range(0, 15));
      a_wr_data = 1'($urandom_range(0, 1));
      a_eval_en = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      a_x       = ($urandom_range(0, 3) == 0) ? a_wr_addr : 4'($urandom_range(0, 15));
      a_inv     = 1'($urandom_range(0, 1));
      exp_f = a_eval_en ? (mt[a_x] ^ a_inv) : prev_f;
      exp_v = a_eval_en;
      if (a_wr_en) mt[a_wr_addr] = a_wr_data;
      tick;
      chk($sformatf("rand%0d f", i), {31'd0, a_f}, {31'd0, exp_f});
      chk($sformatf("rand%0d valid", i), {31'd0, a_fv}, {31'd0, exp_v});
      prev_f = exp_f;
    end
    a_wr_en = 1'b0;
    a_eval_en = 1'b0;
    tick;
    run_scan_a(model_count(mt), "scan-random");

    // Write attempted during SCAN must be dropped; eval still served.
    a_wr_en = 1'b1; a_wr_addr = 4'd3; a_wr_data = 1'b0;
    tick;
    a_wr_en = 1'b0;
    mt[3] = 1'b0;
    a_scan_start = 1'b1;
    tick;
    a_scan_start = 1'b0;
    chk("scanwr busy", {31'd0, a_busy}, 32'd1);
    a_wr_en = 1'b1; a_wr_addr = 4'd3; a_wr_data = 1'b1;
    a_eval_en = 1'b1; a_x = 4'd3; a_inv = 1'b0;
    tick;
    chk("scanwr eval-during-scan f", {31'd0, a_f}, 32'd0);
    chk("scanwr eval-during-scan valid", {31'd0, a_fv}, 32'd1);
    tick;
    a_wr_en = 1'b0;
    a_eval_en = 1'b0;
    guard = 0;
    while (!a_done && guard < 100) begin
      tick;
      guard++;
    end
    chk("scanwr done-seen", {31'd0, a_done}, 32'd1);
    chk("scanwr count", {27'd0, a_count}, model_count(mt));
    tick;
    eval_check(4'd3, 1'b0, "scanwr x=3 after");
    chk("scanwr x=3 literal", {31'd0, a_f}, 32'd0);

    // Same-cycle write and eval on x=5: old bit first, new bit next.
    nb = ~mt[5];
    a_wr_en = 1'b1; a_wr_addr = 4'd5; a_wr_data = nb;
    a_eval_en = 1'b1; a_x = 4'd5; a_inv = 1'b0;
    exp_f = mt[5];
    tick;
    chk("rbw old", {31'd0, a_f}, {31'd0, exp_f});
    a_wr_en = 1'b0;
    a_eval_en = 1'b0;
    mt[5] = nb;
    eval_check(4'd5, 1'b0, "rbw new");

    a_wr_en = 1'b1; a_wr_data = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a_wr_addr = 4'(i);
      tick;
    end
    a_wr_en = 1'b0;
    mt = 16'hFFFF;
    run_scan_a(16, "scan-all-ones");

    // Reset in the middle of a scan: no done pulse, everything back to defaults.
    a_scan_start = 1'b1;
    tick;
    a_scan_start = 1'b0;
    for (int i = 0; i < 7; i++) tick;
    chk("abort busy-before", {31'd0, a_busy}, 32'd1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("abort busy", {31'd0, a_busy}, 32'd0);
    chk("abort done", {31'd0, a_done}, 32'd0);
    chk("abort count", {27'd0, a_count}, 32'd0);
    chk("abort wr_ready", {31'd0, a_wr_ready}, 32'd1);
    done_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      done_seen |= a_done;
      tick;
    end
    chk("abort no-done", {31'd0, done_seen}, 32'd0);
    mt = default_model();
    for (int i = 0; i < 16; i++) eval_check(4'(i), 1'b0, $sformatf("post-reset x=%0d", i));

    // Three-input instance with an all-ones initial table.
    b_scan_start = 1'b1;
    tick;
    b_scan_start = 1'b0;
    busy_n = 0;
    guard = 0;
    while (!b_done && guard < 100) begin
      if (b_busy) busy_n++;
      tick;
      guard++;
    end
    chk("nin3 done-seen", {31'd0, b_done}, 32'd1);
    chk("nin3 busy-cycles", busy_n, 8);
    chk("nin3 count", {28'd0, b_count}, 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
